// File: rtl/ym3438_pkg.sv
// Shared defaults and reg 27h bit positions for the OPN2 timer block.
// TIMER_CSM_EN (optional) enables the CSM key-on output in ym3438_timers.
package ym3438_pkg;
    localparam int TA_WIDTH_DEF    = 10;
    localparam int TB_WIDTH_DEF    = 8;
    localparam int TB_PRESCALE_DEF = 16;

    localparam int R27_TA_LOAD  = 0;
    localparam int R27_TB_LOAD  = 1;
    localparam int R27_TA_EN    = 2;
    localparam int R27_TB_EN    = 3;
    localparam int R27_TA_CLR   = 4;
    localparam int R27_TB_CLR   = 5;
    localparam int R27_MODE_LSB = 6;
    localparam int R27_MODE_MSB = 7;
endpackage

// File: rtl/ym3438_timer_counter.sv
// Up-counter with load-edge detect, reload on overflow and a one-c1-cycle overflow pulse.
module ym3438_timer_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c1,
    input  logic             tick,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    output logic             load_edge,
    output logic             ovf_ev,
    output logic             ovf
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             load_prev_q, load_prev_d;
    logic             pend_q, pend_d;
    logic             ovf_q, ovf_d;

    assign load_edge = c1 & load & ~load_prev_q;
    assign ovf       = ovf_q;

    always_comb begin
        cnt_d       = cnt_q;
        load_prev_d = load_prev_q;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        ovf_ev      = 1'b0;
        if (c1) begin
            load_prev_d = load;
            if (!load) begin
                pend_d = 1'b0;
            end else if (!load_prev_q || pend_q) begin
                // A load edge waits for the next frame tick and replaces that tick's step
                if (tick) begin
                    cnt_d  = period;
                    pend_d = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
            end else if (step) begin
                if (cnt_q == '1) begin
                    cnt_d  = period;
                    ovf_ev = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ovf_d = ovf_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            load_prev_q <= 1'b0;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            load_prev_q <= load_prev_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule

// File: rtl/ym3438_timers.sv
// OPN2 Timer A / Timer B: counters, Timer B prescaler, status flags, IRQ and CSM key-on.
// Define TIMER_CSM_EN to drive csm_keyon from Timer A overflow; otherwise it is tied low.
module ym3438_timers
    import ym3438_pkg::*;
#(
    parameter int TA_WIDTH    = TA_WIDTH_DEF,
    parameter int TB_WIDTH    = TB_WIDTH_DEF,
    parameter int TB_PRESCALE = TB_PRESCALE_DEF
) (
    input  logic                MCLK,
    input  logic                timer_reset,
    input  logic                c1,
    input  logic                fsm_timer_ed,
    input  logic [TA_WIDTH-1:0] ta_period,
    input  logic [TB_WIDTH-1:0] tb_period,
    input  logic                ta_load,
    input  logic                tb_load,
    input  logic                ta_en,
    input  logic                tb_en,
    input  logic                ta_clr,
    input  logic                tb_clr,
    input  logic                csm_mode,
    output logic                flag_a,
    output logic                flag_b,
    output logic                irq,
    output logic                ta_ovf,
    output logic                csm_keyon
);
    localparam int PW = (TB_PRESCALE > 1) ? $clog2(TB_PRESCALE) : 1;

    logic          tick;
    logic          ta_ev, tb_ev, tb_edge, tb_step, pre_wrap;
    logic          unused_ta_edge, unused_tb_ovf;
    logic [PW-1:0] pre_q, pre_d;
    logic          flag_a_q, flag_a_d, flag_b_q, flag_b_d, irq_q, irq_d;

    assign tick     = c1 & fsm_timer_ed;
    assign pre_wrap = (pre_q == PW'(TB_PRESCALE - 1));
    assign tb_step  = tick & pre_wrap & ~tb_edge;

    ym3438_timer_counter #(.WIDTH(TA_WIDTH)) u_ta (
        .clk(MCLK), .rst(timer_reset), .c1(c1), .tick(tick), .step(tick),
        .load(ta_load), .period(ta_period),
        .load_edge(unused_ta_edge), .ovf_ev(ta_ev), .ovf(ta_ovf)
    );

    ym3438_timer_counter #(.WIDTH(TB_WIDTH)) u_tb (
        .clk(MCLK), .rst(timer_reset), .c1(c1), .tick(tick), .step(tb_step),
        .load(tb_load), .period(tb_period),
        .load_edge(tb_edge), .ovf_ev(tb_ev), .ovf(unused_tb_ovf)
    );

    always_comb begin
        pre_d    = pre_q;
        flag_a_d = flag_a_q;
        flag_b_d = flag_b_q;
        irq_d    = irq_q;
        if (c1) begin
            if (tb_edge)
                pre_d = '0;
            else if (tick && tb_load)
                pre_d = pre_wrap ? '0 : pre_q + 1'b1;
            // Set beats clear when both land in the same cycle
            flag_a_d = (ta_ev & ta_en) | (flag_a_q & ~ta_clr);
            flag_b_d = (tb_ev & tb_en) | (flag_b_q & ~tb_clr);
            irq_d    = flag_a_q | flag_b_q;
        end
    end

    always_ff @(posedge MCLK) begin
        if (timer_reset) begin
            pre_q    <= '0;
            flag_a_q <= 1'b0;
            flag_b_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            flag_a_q <= flag_a_d;
            flag_b_q <= flag_b_d;
            irq_q    <= irq_d;
        end
    end

    assign flag_a = flag_a_q;
    assign flag_b = flag_b_q;
    assign irq    = irq_q;

`ifdef TIMER_CSM_EN
    logic csm_q, csm_d;
    always_comb begin
        csm_d = csm_q;
        if (c1) csm_d = ta_ev & csm_mode;
    end
    always_ff @(posedge MCLK) begin
        if (timer_reset) csm_q <= 1'b0;
        else             csm_q <= csm_d;
    end
    assign csm_keyon = csm_q;
`else
    logic unused_csm_mode;
    assign unused_csm_mode = csm_mode;
    assign csm_keyon       = 1'b0;
`endif
endmodule

// File: tb/tb_ym3438_timers.sv
// Directed bench for ym3438_timers; expected outputs queued per step and compared after the edge.
module tb_ym3438_timers;
    logic       MCLK = 1'b0;
    logic       timer_reset = 1'b1;
    logic       c1 = 1'b0, fsm_timer_ed = 1'b0;
    logic [9:0] ta_period = '0;
    logic [7:0] tb_period = '0;
    logic       ta_load = 0, tb_load = 0, ta_en = 0, tb_en = 0;
    logic       ta_clr = 0, tb_clr = 0, csm_mode = 0;
    logic       flag_a, flag_b, irq, ta_ovf, csm_keyon;

    ym3438_timers dut (
        .MCLK(MCLK), .timer_reset(timer_reset), .c1(c1), .fsm_timer_ed(fsm_timer_ed),
        .ta_period(ta_period), .tb_period(tb_period),
        .ta_load(ta_load), .tb_load(tb_load), .ta_en(ta_en), .tb_en(tb_en),
        .ta_clr(ta_clr), .tb_clr(tb_clr), .csm_mode(csm_mode),
        .flag_a(flag_a), .flag_b(flag_b), .irq(irq), .ta_ovf(ta_ovf), .csm_keyon(csm_keyon)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // {flag_a, flag_b, irq, ta_ovf, csm_keyon}
    function automatic logic [4:0] E(input logic fa, input logic fb, input logic iq, input logic ov);
        logic ck;
`ifdef TIMER_CSM_EN
        ck = ov & csm_mode;
`else
        ck = 1'b0;
`endif
        return {fa, fb, iq, ov, ck};
    endfunction

    task automatic drive(input logic c1v, input logic edv, input string tag, input logic [4:0] e);
        exp_t x;
        logic [4:0] obs;
        c1 = c1v;
        fsm_timer_ed = edv;
        sb.push_back('{tag, e});
        @(posedge MCLK);
        #1;
        x   = sb.pop_front();
        obs = {flag_a, flag_b, irq, ta_ovf, csm_keyon};
        n_cmp++;
        assert (obs === x.exp) else begin
            n_bad++;
            $error("FAIL %s: observed fa/fb/irq/ovf/csm=%b expected %b", x.tag, obs, x.exp);
        end
    endtask

    initial begin
        @(posedge MCLK); #1;
        drive(1, 1, "reset0", E(0,0,0,0));
        drive(1, 1, "reset1", E(0,0,0,0));
        timer_reset = 0;

        // Timer A: period 1020 -> load tick + 3 steps, overflow on the following tick
        ta_period = 10'd1020; ta_en = 1; ta_load = 1;
        drive(1, 0, "a_edge", E(0,0,0,0));
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, "a_tick", E(0,0,0,0));
            drive(0, 1, "a_gap",  E(0,0,0,0));
        end
        drive(1, 1, "a_ovf",  E(1,0,0,1));
        drive(0, 1, "a_hold", E(1,0,0,1));
        drive(1, 0, "a_irq",  E(1,0,1,0));
        for (int i = 0; i < 3; i++) drive(1, 1, "a_run", E(1,0,1,0));
        ta_clr = 1;
        drive(1, 1, "a_ovf_clr", E(1,0,1,1));
        ta_clr = 0;
        drive(1, 0, "a_after", E(1,0,1,0));
        ta_clr = 1;
        drive(1, 0, "a_clr", E(0,0,1,0));
        ta_clr = 0;
        drive(1, 0, "a_irq0", E(0,0,0,0));

        // Flag enable off across an overflow
        ta_en = 0;
        for (int i = 0; i < 3; i++) drive(1, 1, "a_noen_run", E(0,0,0,0));
        drive(1, 1, "a_noen_ovf", E(0,0,0,1));
        drive(1, 0, "a_noen_end", E(0,0,0,0));

        // Load toggle 1->0->1 reloads the new period
        ta_load = 0;
        drive(1, 0, "a_off", E(0,0,0,0));
        ta_period = 10'd1022;
        for (int i = 0; i < 6; i++) drive(1, 1, "a_held", E(0,0,0,0));
        ta_load = 1;
        drive(1, 0, "a_reedge", E(0,0,0,0));
        drive(1, 1, "a_reload", E(0,0,0,0));
        drive(1, 1, "a_r1023",  E(0,0,0,0));
        drive(1, 1, "a_r_ovf",  E(0,0,0,1));
        drive(1, 0, "a_r_end",  E(0,0,0,0));

        // Max period: overflow (and CSM key-on when built in) every tick
        csm_mode = 1; ta_load = 0;
        drive(1, 0, "csm_off", E(0,0,0,0));
        ta_period = 10'd1023; ta_load = 1;
        drive(1, 0, "csm_edge", E(0,0,0,0));
        drive(1, 1, "csm_load", E(0,0,0,0));
        for (int i = 0; i < 3; i++) drive(1, 1, "csm_tick", E(0,0,0,1));
        drive(1, 0, "csm_end", E(0,0,0,0));
        csm_mode = 0;
        drive(1, 1, "csm_mode0", E(0,0,0,1));
        drive(1, 0, "csm_mode0_end", E(0,0,0,0));
        ta_load = 0;
        drive(1, 0, "a_stop", E(0,0,0,0));

        // Timer B: period 254, prescale 16 -> flag after 32 ticks
        tb_period = 8'd254; tb_en = 1; tb_load = 1;
        drive(1, 0, "b_edge", E(0,0,0,0));
        for (int i = 0; i < 31; i++) begin
            drive(1, 1, "b_tick", E(0,0,0,0));
            drive(0, 1, "b_gap",  E(0,0,0,0));
        end
        drive(1, 1, "b_ovf", E(0,1,0,0));
        drive(1, 0, "b_irq", E(0,1,1,0));
        tb_clr = 1;
        drive(1, 0, "b_clr", E(0,0,1,0));
        tb_clr = 0;
        drive(1, 0, "b_irq0", E(0,0,0,0));

        // Raise flag_a, then reset mid-count
        ta_en = 1; ta_load = 1;
        drive(1, 0, "p_edge", E(0,0,0,0));
        drive(1, 1, "p_load", E(0,0,0,0));
        drive(1, 1, "p_ovf",  E(1,0,0,1));
        drive(1, 0, "p_irq",  E(1,0,1,0));
        timer_reset = 1; ta_load = 0; tb_load = 0;
        drive(1, 1, "rst_mid",  E(0,0,0,0));
        drive(0, 0, "rst_hold", E(0,0,0,0));
        timer_reset = 0;
        for (int i = 0; i < 3; i++) drive(1, 1, "post_rst_idle", E(0,0,0,0));
        ta_load = 1;
        drive(1, 0, "post_edge", E(0,0,0,0));
        drive(1, 1, "post_load", E(0,0,0,0));
        drive(1, 1, "post_ovf",  E(1,0,0,1));
        drive(1, 0, "post_irq",  E(1,0,1,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
